// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master controllers: state set, bit-phase
// numbering and the R/W bit value used for writes.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } state_t;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_RISE   = 2'd1;
  localparam logic [1:0] PH_SAMPLE = 2'd2;
  localparam logic [1:0] PH_FALL   = 2'd3;

  localparam logic W_BIT = 1'b0;

endpackage

// File: rtl/i2c_tick_detect.sv
// Rising-edge detector on the baud-rate generator's ClockI2C square wave.
// Tick is a one-clock pulse in the cycle after each ClockI2C rising edge.
module i2c_tick_detect (
  input  logic clock,
  input  logic Reset,
  input  logic ClockI2C,
  output logic Tick
);

  logic clk_i2c_q;

  // Delayed copy of ClockI2C for edge detection.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) clk_i2c_q <= 1'b0;
    else        clk_i2c_q <= ClockI2C;
  end

  assign Tick = ClockI2C & ~clk_i2c_q;

endmodule

// File: rtl/i2c_write_controller.sv
// Single-byte I2C master write: START, address + W, ACK, data byte, ACK, STOP.
// Each bit spans four Ticks; SCL and SDAOutEn are registered outputs decoded
// from the next state/phase so they line up with the state register.
module i2c_write_controller
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  ClockI2C,
  input  logic                  Go,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  SDAIn,
  output logic                  BaudEnable,
  output logic                  SCL,
  output logic                  SDAOutEn,
  output logic                  Busy,
  output logic                  Done,
  output logic                  AckError
);

  localparam logic [2:0] ADDR_LAST = 3'(ADDR_WIDTH);
  localparam logic [2:0] DATA_LAST = 3'(DATA_WIDTH - 1);

  state_t                state, state_n;
  logic [1:0]            phase, phase_n;
  logic [2:0]            bitcnt, bitcnt_n;
  logic [ADDR_WIDTH:0]   addr_sr, addr_sr_n;
  logic [DATA_WIDTH-1:0] data_sr, data_sr_n;
  logic                  ack_err, ack_err_n;
  logic                  done_q, done_n;
  logic                  scl_q, scl_n;
  logic                  sda_oe_q, sda_oe_n;
  logic                  tick;

  i2c_tick_detect u_tick (
    .clock    (clock),
    .Reset    (Reset),
    .ClockI2C (ClockI2C),
    .Tick     (tick)
  );

  // Next-state logic plus pad-level decode of the next state/phase.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bitcnt_n  = bitcnt;
    addr_sr_n = addr_sr;
    data_sr_n = data_sr;
    ack_err_n = ack_err;
    done_n    = 1'b0;

    if (state == IDLE) begin
      // A coincident Tick is deliberately not consumed on acceptance.
      if (Go) begin
        state_n   = START;
        phase_n   = PH_SETUP;
        bitcnt_n  = '0;
        addr_sr_n = {Address, W_BIT};
        data_sr_n = Data;
        ack_err_n = 1'b0;
      end
    end else if (tick) begin
      phase_n = phase + 2'd1;
      if ((state == ACK1 || state == ACK2) && phase == PH_SAMPLE && SDAIn)
        ack_err_n = 1'b1;
      if (phase == PH_FALL) begin
        case (state)
          START: begin
            state_n  = ADDR;
            bitcnt_n = '0;
          end
          ADDR: begin
            addr_sr_n = {addr_sr[ADDR_WIDTH-1:0], 1'b0};
            bitcnt_n  = bitcnt + 3'd1;
            if (bitcnt == ADDR_LAST) begin
              state_n  = ACK1;
              bitcnt_n = '0;
            end
          end
          ACK1: state_n = ack_err ? STOP : DATA;
          DATA: begin
            data_sr_n = {data_sr[DATA_WIDTH-2:0], 1'b0};
            bitcnt_n  = bitcnt + 3'd1;
            if (bitcnt == DATA_LAST) begin
              state_n  = ACK2;
              bitcnt_n = '0;
            end
          end
          ACK2: state_n = STOP;
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end

    scl_n    = 1'b1;
    sda_oe_n = 1'b0;
    case (state_n)
      START: begin
        scl_n    = (phase_n != PH_FALL);
        sda_oe_n = (phase_n == PH_SAMPLE) || (phase_n == PH_FALL);
      end
      ADDR: begin
        scl_n    = (phase_n == PH_RISE) || (phase_n == PH_SAMPLE);
        sda_oe_n = ~addr_sr_n[ADDR_WIDTH];
      end
      DATA: begin
        scl_n    = (phase_n == PH_RISE) || (phase_n == PH_SAMPLE);
        sda_oe_n = ~data_sr_n[DATA_WIDTH-1];
      end
      ACK1, ACK2: begin
        scl_n    = (phase_n == PH_RISE) || (phase_n == PH_SAMPLE);
        sda_oe_n = 1'b0;
      end
      STOP: begin
        scl_n    = (phase_n != PH_SETUP);
        sda_oe_n = (phase_n == PH_SETUP) || (phase_n == PH_RISE);
      end
      default: begin
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
      end
    endcase
  end

  // State, datapath and registered pad outputs.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      phase    <= PH_SETUP;
      bitcnt   <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      ack_err  <= 1'b0;
      done_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bitcnt   <= bitcnt_n;
      addr_sr  <= addr_sr_n;
      data_sr  <= data_sr_n;
      ack_err  <= ack_err_n;
      done_q   <= done_n;
      scl_q    <= scl_n;
      sda_oe_q <= sda_oe_n;
    end
  end

  assign Busy       = (state != IDLE);
  assign BaudEnable = Busy;
  assign Done       = done_q;
  assign AckError   = ack_err;
  assign SCL        = scl_q;
  assign SDAOutEn   = sda_oe_q;

endmodule

// File: tb/tb_i2c_write_controller.sv
// Self-checking bench for i2c_write_controller: bus monitor, ACK-driving slave
// and a bit-sequence / tick-count reference model.
`timescale 1ns/1ps
module tb_i2c_write_controller;

  logic       clock = 1'b0;
  logic       Reset;
  logic       ClockI2C;
  logic       Go;
  logic [6:0] Address;
  logic [7:0] Data;
  logic       SDAIn;
  logic       BaudEnable, SCL, SDAOutEn, Busy, Done, AckError;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned cyc = 0;
  logic        ck_q = 1'b0;
  logic        tick_now = 1'b0;
  logic        prev_scl = 1'b1, prev_oe = 1'b0, prev_busy = 1'b0;
  int          rises = 0;
  int          ticks = 0, ticks_at_done = -1, done_cnt = 0;
  int          start_cnt = 0, stop_cnt = 0, bad_cnt = 0;
  logic        bits_q[$];
  logic        ack1_low = 1'b1, ack2_low = 1'b1;

  i2c_write_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .ClockI2C   (ClockI2C),
    .Go         (Go),
    .Address    (Address),
    .Data       (Data),
    .SDAIn      (SDAIn),
    .BaudEnable (BaudEnable),
    .SCL        (SCL),
    .SDAOutEn   (SDAOutEn),
    .Busy       (Busy),
    .Done       (Done),
    .AckError   (AckError)
  );

  always #5 clock = ~clock;

  // Slave: pulls SDA low while SCL is high during the 9th / 18th SCL pulse.
  assign SDAIn = !(SCL && ((rises == 9 && ack1_low) || (rises == 18 && ack2_low)));

  // ClockI2C source (period 8 clocks) and bus monitor, both on the falling edge.
  initial begin
    ClockI2C = 1'b0;
    forever begin
      @(negedge clock);
      ck_q     = ClockI2C;
      cyc      = cyc + 1;
      ClockI2C = ((cyc % 8) < 4);
      tick_now = ClockI2C && !ck_q;
      if (Done) begin
        done_cnt++;
        ticks_at_done = ticks;
      end
      if (Busy && !prev_busy) ticks = 0;
      if (Busy && tick_now) ticks++;
      if (SCL && !prev_scl) begin
        rises++;
        bits_q.push_back(!SDAOutEn);
      end
      if (SDAOutEn != prev_oe) begin
        if (SCL && prev_scl) begin
          if (SDAOutEn) start_cnt++;
          else          stop_cnt++;
        end else if (SCL || prev_scl) begin
          bad_cnt++;
        end
      end
      prev_scl  = SCL;
      prev_oe   = SDAOutEn;
      prev_busy = Busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected master SDA level at every SCL rise, including ACK slots and STOP.
  function automatic void model_bits(input logic [6:0] a, input logic [7:0] d,
                                     input logic nack1, output int n, output logic [31:0] w);
    logic q[$];
    for (int i = 6; i >= 0; i--) q.push_back(a[i]);
    q.push_back(1'b0);
    q.push_back(1'b1);
    if (!nack1) begin
      for (int i = 7; i >= 0; i--) q.push_back(d[i]);
      q.push_back(1'b1);
    end
    q.push_back(1'b0);
    n = q.size();
    w = '0;
    foreach (q[i]) w = {w[30:0], q[i]};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_scl"},  SCL,        1'b1);
    check({tag, "_oe"},   SDAOutEn,   1'b0);
    check({tag, "_busy"}, Busy,       1'b0);
    check({tag, "_baud"}, BaudEnable, 1'b0);
    check({tag, "_done"}, Done,       1'b0);
    check({tag, "_ackerr"}, AckError, 1'b0);
  endtask

  task automatic clear_monitor();
    rises = 0;
    bits_q.delete();
    done_cnt = 0;
    start_cnt = 0;
    stop_cnt = 0;
    bad_cnt = 0;
    ticks_at_done = -1;
  endtask

  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic a1low,
                         input logic a2low, input logic on_tick, input logic dup,
                         input int hold, input logic b2b, input string tag);
    int          n_exp, n_got, budget;
    logic [31:0] w_exp, w_got;
    logic        nack1;
    if (!b2b) begin
      @(posedge clock); #1;
    end
    ack1_low = a1low;
    ack2_low = a2low;
    clear_monitor();
    if (!b2b) begin
      if (on_tick) begin
        budget = 0;
        while ((cyc % 8) != 7 && budget < 16) begin
          @(posedge clock); #1;
          budget++;
        end
      end else begin
        repeat ($urandom_range(0, 7)) begin
          @(posedge clock); #1;
        end
      end
    end
    Address = a;
    Data    = d;
    Go      = 1'b1;
    @(posedge clock); #1;
    Go = 1'b0;
    check({tag, "_busy_acc"},  Busy,       1'b1);
    check({tag, "_baud_acc"},  BaudEnable, 1'b1);
    check({tag, "_ackerr_acc"}, AckError,  1'b0);
    Address = 7'($urandom);
    Data    = 8'($urandom);
    if (dup) begin
      budget = 0;
      while (rises < 3 && budget < 200) begin
        @(posedge clock); #1;
        budget++;
      end
      Data = 8'hFF;
      Go   = 1'b1;
      @(posedge clock); #1;
      Go = 1'b0;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 2000) begin
      @(posedge clock); #1;
      budget++;
    end
    check({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    repeat (hold) @(posedge clock);
    #1;
    nack1 = !a1low;
    check({tag, "_ticks"},  ticks_at_done, nack1 ? 44 : 80);
    check({tag, "_ackerr"}, AckError, nack1 || !a2low);
    check({tag, "_ndone"},  done_cnt, 1);
    check({tag, "_busy_end"}, Busy, 1'b0);
    model_bits(a, d, nack1, n_exp, w_exp);
    n_got = bits_q.size();
    w_got = '0;
    foreach (bits_q[i]) w_got = {w_got[30:0], bits_q[i]};
    check({tag, "_nbits"}, n_got, n_exp);
    check({tag, "_bits"},  w_got, w_exp);
    check({tag, "_start"}, start_cnt, 1);
    check({tag, "_stop"},  stop_cnt, 1);
    check({tag, "_sda_glitch"}, bad_cnt, 0);
  endtask

  initial begin
    int budget;
    int mode;
    Reset   = 1'b0;
    Go      = 1'b0;
    Address = '0;
    Data    = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("rst_init");
    Reset = 1'b1;

    run_txn(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 24, 1'b0, "basic");
    run_txn(7'h50, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 40, 1'b0, "nack_addr");

    // Reset while idle with AckError still held from the NACK.
    @(posedge clock); #2;
    Reset = 1'b0;
    #1;
    check_reset_vals("rst_idle");
    #1;
    Reset = 1'b1;

    run_txn(7'h50, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 24, 1'b0, "nack_data");
    run_txn(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 24, 1'b0, "go_busy");

    // Reset in the middle of the address byte.
    @(posedge clock); #1;
    clear_monitor();
    Address = 7'h50;
    Data    = 8'hA5;
    Go      = 1'b1;
    @(posedge clock); #1;
    Go = 1'b0;
    budget = 0;
    while (rises < 4 && budget < 300) begin
      @(posedge clock); #1;
      budget++;
    end
    check("rst_mid_reach", (rises >= 4), 1'b1);
    @(posedge clock); #2;
    Reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    #1;
    Reset = 1'b1;

    run_txn(7'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, "go_on_tick");
    run_txn(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 24, 1'b1, "back2back");

    for (int k = 0; k < 6; k++) begin
      mode = $urandom_range(0, 2);
      run_txn(7'($urandom), 8'($urandom), (mode != 1), (mode != 2), 1'($urandom_range(0, 1)),
              1'b0, 24, 1'b0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
